shift_word_tx: RTL and testbench

Parallel-to-serial word transmitter that drives the serial-in side of the team's left/right/load shift register. It accepts an n-bit word over a valid/ready handshake and emits it one bit per clock on `sout`. Alongside each bit it asserts the matching `left` or `right` shift strobe, so a downstream shift register rebuilds the word in its original bit order. It sits in the FSM lab datapath between the word source and the shift register.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_bit_counter.sv | 27 ++
 rtl/shift_word_tx.sv | 114 +++++++++++
 tb/tb_shift_word_tx.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift-register lab datapath: transmitter FSM states and bit-order codes.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit counter for shift_word_tx: synchronous clear, increment, terminal flag at N-1.
module shift_bit_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CW'(N - 1));

endmodule

// File: rtl/shift_word_tx.sv
// Parallel-to-serial word transmitter driving a left/right shift register.
// Optional even-parity trailer cycle when SHIFT_TX_PARITY_EN is defined.
module shift_word_tx
    import shift_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tx_valid,
    input  logic [N-1:0] tx_data,
    input  logic         tx_dir,
    output logic         tx_ready,
    output logic         sout,
    output logic         sh_left,
    output logic         sh_right,
    output logic         par_strobe,
    output logic         done
);

    tx_state_t    state, state_nx;
    logic [N-1:0] sr;
    logic         dir_q;
    logic         hs;
    logic         last_bit;

    // Gating with rst keeps the source from seeing ready during reset.
    assign tx_ready = (state == IDLE) && !rst;
    assign hs       = tx_valid && tx_ready;

    shift_bit_counter #(.N(N)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hs),
        .inc (state == SHIFT),
        .tc  (last_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (hs) begin
            sr    <= tx_data;
            dir_q <= tx_dir;
        end else if (state == SHIFT) begin
            sr <= (dir_q == DIR_LSB_FIRST) ? {1'b0, sr[N-1:1]} : {sr[N-2:0], 1'b0};
        end
    end

`ifdef SHIFT_TX_PARITY_EN
    // Parity is taken from the word as accepted, since sr is consumed while shifting.
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_q <= 1'b0;
        else if (hs)
            par_q <= ^tx_data;
    end
`endif

    always_comb begin
        state_nx = state;
        sout     = 1'b0;
        sh_left  = 1'b0;
        sh_right = 1'b0;
        done     = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
        par_strobe = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (hs)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                sout     = (dir_q == DIR_LSB_FIRST) ? sr[0] : sr[N-1];
                sh_left  = (dir_q == DIR_MSB_FIRST);
                sh_right = (dir_q == DIR_LSB_FIRST);
                if (last_bit)
`ifdef SHIFT_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = DONE;
`endif
            end
`ifdef SHIFT_TX_PARITY_EN
            PARITY: begin
                sout       = par_q;
                par_strobe = 1'b1;
                state_nx   = DONE;
            end
`endif
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifndef SHIFT_TX_PARITY_EN
    assign par_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_shift_word_tx.sv
// Directed bench for shift_word_tx (N=4) with a downstream shift-register model.
module tb_shift_word_tx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_valid;
    logic [N-1:0] tx_data;
    logic         tx_dir;
    logic         tx_ready, sout, sh_left, sh_right, par_strobe, done;
    logic [N-1:0] dsr;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_word_tx #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_dir     (tx_dir),
        .tx_ready   (tx_ready),
        .sout       (sout),
        .sh_left    (sh_left),
        .sh_right   (sh_right),
        .par_strobe (par_strobe),
        .done       (done)
    );

    // Downstream left/right shift register fed by sout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dsr <= '0;
        else if (sh_left)
            dsr <= {dsr[N-2:0], sout};
        else if (sh_right)
            dsr <= {sout, dsr[N-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake now (cycle 0), then check bits, optional parity, done, ready.
    // exp_stream[N-1] is the bit expected on cycle 1.
    task automatic send(input string tag, input logic [N-1:0] data, input logic dir,
                        input logic [N-1:0] exp_stream, input logic exp_par, input bit hold);
        logic [1:0] exp_sh;
        exp_sh   = dir ? 2'b01 : 2'b10;
        tx_valid = 1'b1;
        tx_data  = data;
        tx_dir   = dir;
        chk({tag, ".ready0"}, 32'(tx_ready), 32'd1);
        step();
        if (!hold) tx_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hold && i == 1) tx_data = '0;
            chk($sformatf("%s.bit%0d", tag, i), 32'(sout), 32'(exp_stream[N-1-i]));
            chk($sformatf("%s.sh%0d", tag, i), 32'({sh_left, sh_right}), 32'(exp_sh));
            chk($sformatf("%s.busy%0d", tag, i), 32'({tx_ready, done, par_strobe}), 32'd0);
            step();
        end
`ifdef SHIFT_TX_PARITY_EN
        chk({tag, ".par"}, 32'({sout, par_strobe, sh_left, sh_right}), 32'({exp_par, 3'b100}));
        step();
`else
        chk({tag, ".nopar"}, 32'(par_strobe), 32'(exp_par & 1'b0));
`endif
        chk({tag, ".done"}, 32'({done, tx_ready, sh_left, sh_right}), 32'b1000);
        chk({tag, ".dsr"}, 32'(dsr), 32'(data));
        step();
        chk({tag, ".ready1"}, 32'({tx_ready, done}), 32'b10);
    endtask

    initial begin
        bit found;
        int dseen;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_dir   = 1'b0;
        #1;
        chk("rst.ready", 32'(tx_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst.release", 32'({tx_ready, sout, sh_left, sh_right, par_strobe, done}), 32'b100000);

        // MSB first / LSB first of the same word
        send("msb1011", 4'b1011, 1'b0, 4'b1011, 1'b1, 1'b0);
        send("lsb1011", 4'b1011, 1'b1, 4'b1101, 1'b1, 1'b0);

        // Data changes mid-word and valid stays high: next word (0000) taken right after done
        send("hold0110", 4'b0110, 1'b1, 4'b0110, 1'b0, 1'b1);
        step();
        chk("hold.next", 32'({sout, sh_left, sh_right}), 32'b001);
        tx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (done) found = 1'b1;
            else step();
        end
        chk("hold.next_done", 32'(found), 32'd1);
        chk("hold.next_dsr", 32'(dsr), 32'd0);
        step();

        send("msb0111", 4'b0111, 1'b0, 4'b0111, 1'b1, 1'b0);

        // Reset on cycle 2 of a word
        tx_valid = 1'b1;
        tx_data  = 4'b1011;
        tx_dir   = 1'b0;
        step();
        tx_valid = 1'b0;
        step();
        chk("mid.pre", 32'(sh_left), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid.rst", 32'({tx_ready, sout, sh_left, sh_right, par_strobe, done}), 32'd0);
        #3;
        rst = 1'b0;
        step();
        chk("mid.ready", 32'(tx_ready), 32'd1);
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dseen++;
            step();
        end
        chk("mid.nodone", 32'(dseen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
